// File: rtl/updown_counter_ctrl_pkg.sv
// Shared types and constants for the run/stop/clear decimal up/down counter.
package updown_pkg;

    localparam int CNT_W = 14;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        RUN   = 2'd1,
        CLEAR = 2'd2
    } state_t;

endpackage

// File: rtl/updown_counter_ctrl_if.sv
// Button/switch inputs and count/tick/running outputs of the counter controller.
interface updown_counter_ctrl_if;
    import updown_pkg::*;

    logic             btn_run_stop;
    logic             btn_clear;
    logic             sw_mode;
    logic [CNT_W-1:0] count_data;
    logic             tick_100ms;
    logic             running;

    modport master (
        output btn_run_stop, btn_clear, sw_mode,
        input  count_data, tick_100ms, running
    );

    modport slave (
        input  btn_run_stop, btn_clear, sw_mode,
        output count_data, tick_100ms, running
    );

endinterface

// File: rtl/updown_counter_ctrl_tick_gen.sv
// Free-running prescaler that emits a registered one-cycle pulse every DIV clocks.
module tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int PW = $clog2(DIV);

    logic [PW-1:0] presc_q;
    logic          tick_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else if (presc_q == PW'(DIV - 1)) begin
            presc_q <= '0;
            tick_q  <= 1'b1;
        end else begin
            presc_q <= presc_q + 1'b1;
            tick_q  <= 1'b0;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/updown_counter_ctrl.sv
// Run/stop/clear controlled 0..MAX_COUNT up/down counter with a free-running tick.
// Define UPDOWN_SATURATE_EN to hold at the bounds and drop to STOP instead of wrapping.
module updown_counter_ctrl
    import updown_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int TICK_HZ   = 10,
    parameter int MAX_COUNT = 9999
) (
    input  logic clk,
    input  logic rst,
    updown_counter_ctrl_if.slave bus
);

    localparam int               DIV   = CLK_FREQ / TICK_HZ;
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);

    state_t           state_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             btn_run_stop_d, btn_clear_d;
    logic             tick_q;
    logic             sat_hit;
    logic             rs_edge, clr_edge;

    tick_gen #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_q)
    );

    assign rs_edge  = bus.btn_run_stop & ~btn_run_stop_d;
    assign clr_edge = bus.btn_clear    & ~btn_clear_d;

    always_comb begin
        count_d = count_q;
        sat_hit = 1'b0;
        if (tick_q && state_q == RUN) begin
            if (bus.sw_mode == DIR_UP) begin
                if (count_q >= MAX_C) begin
`ifdef UPDOWN_SATURATE_EN
                    sat_hit = 1'b1;
`else
                    count_d = '0;
`endif
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (count_q == '0) begin
`ifdef UPDOWN_SATURATE_EN
                    sat_hit = 1'b1;
`else
                    count_d = MAX_C;
`endif
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    // Clear wins over run/stop and over a coincident tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= STOP;
            count_q        <= '0;
            btn_run_stop_d <= 1'b1;
            btn_clear_d    <= 1'b1;
        end else begin
            btn_run_stop_d <= bus.btn_run_stop;
            btn_clear_d    <= bus.btn_clear;
            if (clr_edge) begin
                state_q <= CLEAR;
                count_q <= '0;
            end else begin
                count_q <= count_d;
                case (state_q)
                    STOP:    if (rs_edge) state_q <= RUN;
                    RUN:     if (rs_edge || sat_hit) state_q <= STOP;
                    CLEAR:   state_q <= STOP;
                    default: state_q <= STOP;
                endcase
            end
        end
    end

    assign bus.count_data = count_q;
    assign bus.tick_100ms = tick_q;
    assign bus.running    = (state_q == RUN);

endmodule

// File: tb/tb_updown_counter_ctrl.sv
// Scoreboard bench: each observed tick's expected resulting count is queued and
// compared one cycle after the tick; control/reset behaviour is checked directly.
module tb_updown_counter_ctrl;
    import updown_pkg::*;

    logic clk;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   exp_q[$];
    logic tick_prev = 1'b0;

    updown_counter_ctrl_if bus ();

    updown_counter_ctrl #(
        .CLK_FREQ  (100),
        .TICK_HZ   (10),
        .MAX_COUNT (9999)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int want);
        n_chk++;
        if (act == want) n_pass++;
        else $display("FAIL %s act=%0d exp=%0d", tag, act, want);
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!bus.tick_100ms && n < 25);
        if (!bus.tick_100ms) chk("tick_timeout", 0, 1);
    endtask

    task automatic press_run();
        bus.btn_run_stop = 1'b1;
        cyc();
        bus.btn_run_stop = 1'b0;
    endtask

    // Count is compared in the cycle following each tick.
    always @(negedge clk) begin
        if (tick_prev) begin
            if (exp_q.size() > 0) chk("tick_count", int'(bus.count_data), exp_q.pop_front());
            else chk("sb_underflow", 0, 1);
        end
        tick_prev = bus.tick_100ms;
    end

    initial begin
        #100000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ev;
        int n;
        rst              = 1'b1;
        bus.btn_run_stop = 1'b0;
        bus.btn_clear    = 1'b0;
        bus.sw_mode      = DIR_UP;
        #1;
        chk("rst_count", int'(bus.count_data), 0);
        chk("rst_tick", int'(bus.tick_100ms), 0);
        chk("rst_running", int'(bus.running), 0);
        #1 rst = 1'b0;

        // idle: ticks at cycles 10..50, count frozen at 0
        for (int c = 1; c <= 50; c++) begin
            cyc();
            chk("idle_tick", int'(bus.tick_100ms), (c % 10 == 0) ? 1 : 0);
            if (bus.tick_100ms) exp_q.push_back(0);
        end
        chk("idle_running", int'(bus.running), 0);

        // run up for three ticks, then stop and confirm the count freezes
        cyc();
        bus.btn_run_stop = 1'b1;
        cyc();
        chk("run_on", int'(bus.running), 1);
        bus.btn_run_stop = 1'b0;
        ev = 0;
        repeat (3) begin
            wait_tick();
            ev++;
            exp_q.push_back(ev);
        end
        cyc();
        press_run();
        chk("run_off", int'(bus.running), 0);
        repeat (2) begin
            wait_tick();
            exp_q.push_back(3);
        end

        // clear, then count down from 0
        cyc();
        bus.btn_clear = 1'b1;
        cyc();
        chk("clr_zero", int'(bus.count_data), 0);
        chk("clr_running", int'(bus.running), 0);
        bus.btn_clear = 1'b0;
        bus.sw_mode   = DIR_DOWN;
        cyc();
        cyc();
        press_run();
        chk("dn_running", int'(bus.running), 1);
`ifdef UPDOWN_SATURATE_EN
        wait_tick();
        exp_q.push_back(0);
        cyc();
        chk("sat_dn_stop", int'(bus.running), 0);
        press_run();
        wait_tick();
        exp_q.push_back(0);
        cyc();
        chk("sat_dn_restop", int'(bus.running), 0);
        bus.sw_mode = DIR_UP;
        press_run();
        wait_tick();
        exp_q.push_back(1);
`else
        wait_tick();
        exp_q.push_back(9999);
        cyc();
        chk("wrap_dn_running", int'(bus.running), 1);
        wait_tick();
        exp_q.push_back(9998);
        cyc();
        bus.sw_mode = DIR_UP;
        wait_tick();
        exp_q.push_back(9999);
        wait_tick();
        exp_q.push_back(0);
        wait_tick();
        exp_q.push_back(1);
`endif

        // simultaneous run_stop and clear edges while running
        cyc();
        bus.btn_run_stop = 1'b1;
        bus.btn_clear    = 1'b1;
        cyc();
        chk("sim_count", int'(bus.count_data), 0);
        chk("sim_state_clr", int'(dut.state_q), int'(CLEAR));
        chk("sim_running", int'(bus.running), 0);
        bus.btn_run_stop = 1'b0;
        bus.btn_clear    = 1'b0;
        cyc();
        chk("sim_state_stop", int'(dut.state_q), int'(STOP));
        chk("sim_running2", int'(bus.running), 0);
        wait_tick();
        exp_q.push_back(0);

        // count up to 42, then async reset with run_stop held across it
        cyc();
        bus.sw_mode = DIR_UP;
        press_run();
        ev = 0;
        repeat (42) begin
            wait_tick();
            ev++;
            exp_q.push_back(ev);
        end
        cyc();
        cyc();
        chk("pre_rst_count", int'(bus.count_data), 42);
        bus.btn_run_stop = 1'b1;
        rst              = 1'b1;
        #1;
        chk("arst_count", int'(bus.count_data), 0);
        chk("arst_running", int'(bus.running), 0);
        chk("arst_tick", int'(bus.tick_100ms), 0);
        cyc();
        cyc();
        rst = 1'b0;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!bus.tick_100ms && n < 30);
        chk("first_tick_cyc", n, 10);
        if (bus.tick_100ms) exp_q.push_back(0);
        chk("held_no_run", int'(bus.running), 0);
        bus.btn_run_stop = 1'b0;
        wait_tick();
        exp_q.push_back(0);
        chk("release_no_run", int'(bus.running), 0);
        cyc();
        cyc();
        chk("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/updown_counter_ctrl.md
# updown_counter_ctrl

Run/stop/clear controlled decimal up/down counter that produces the 0-9999 value and the 100 ms tick consumed by the FND display controller. It sits directly upstream of the display stage: its `count_data` drives the display's 14-bit data input, and its `tick_100ms` drives the display's blink tick input. Button inputs arrive already synchronized and debounced.

## Interface
- `CLK_FREQ`, default 100_000_000: clk frequency in Hz.
- `TICK_HZ`, default 10: count and tick rate in Hz. The divide ratio is `DIV = CLK_FREQ/TICK_HZ`, and it must be ≥ 2.
- `MAX_COUNT`, default 9999: upper count bound. It must be ≤ 16383.
- `clk`, input, 1: system clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `btn_run_stop`, input, 1: level input; its rising edge toggles run/stop.
- `btn_clear`, input, 1: level input; its rising edge clears the count.
- `sw_mode`, input, 1: direction select, 0 = up, 1 = down. Sampled on every tick.
- `count_data`, output, 14: current count, 0..MAX_COUNT.
- `tick_100ms`, output, 1: one-clk pulse every `DIV` cycles. Free-running.
- `running`, output, 1: high while the FSM is in RUN.

## Operation
- Edge detect:
  - `btn_*_d` registers hold the previous input level. Both reset to 1, so a button held through reset produces no edge.
  - `edge = btn & ~btn_d`.
- FSM states and transitions:
  - STOP: run_stop edge → RUN.
  - RUN: run_stop edge → STOP.
  - CLEAR: unconditional → STOP after exactly one cycle.
  - A clear edge in any state → CLEAR, and sets count to 0 on that same edge.
- Simultaneous run_stop and clear edges: clear wins and the run_stop edge is discarded.
- Counting happens only when `tick_100ms` is high and the state is RUN.
  - Up: MAX_COUNT → 0, otherwise +1.
  - Down: 0 → MAX_COUNT, otherwise −1.
- Arithmetic is 14-bit unsigned. The count never leaves 0..MAX_COUNT.
- A tick in STOP or CLEAR leaves the count unchanged.
- A `sw_mode` change mid-run takes effect on the next tick. There is no glitch and no extra step.
- Tick generator:
  - The prescaler counts 0..DIV−1 and wraps.
  - `tick_100ms` is registered and is high for the one cycle after the prescaler reaches DIV−1.
  - The prescaler runs regardless of FSM state, so display blinking continues while stopped.
- `running` is decoded from the state register.

## Timing
- Reset values: `count_data` = 0, `tick_100ms` = 0, `running` = 0, state = STOP, prescaler = 0, `btn_*_d` = 1.
- Button-to-state latency:
  - The state changes at the first clk edge at which the button is sampled high with `btn_d` low.
  - `running` reflects the new state in the following cycle.
- Clear latency: `count_data` reads 0 in the cycle after the clear edge is sampled.
- Tick-to-count latency: if `tick_100ms` is high in cycle N, `count_data` holds its new value in cycle N+1.
- First tick after reset release: cycle DIV, then every DIV cycles.
- Reset mid-operation: all state returns to reset values immediately, with no clk needed. Counting resumes only after a fresh run_stop edge.
- A button held high produces exactly one edge. Release produces no action.

## Configuration
- `UPDOWN_SATURATE_EN`:
  - Defined:
    - Up counting at MAX_COUNT holds MAX_COUNT; down counting at 0 holds 0.
    - On that same tick the FSM forces RUN → STOP.
    - A subsequent run_stop edge re-enters RUN, and the count moves only if `sw_mode` points away from the bound.
  - Undefined: wrap-around as described in Operation.

## Structure
- Package `updown_pkg`:
  - State enum `state_t` {STOP, RUN, CLEAR}, 2-bit.
  - Constant `CNT_W = 14`.
  - Direction constants `DIR_UP = 1'b0` and `DIR_DOWN = 1'b1`.
- Sub-module `tick_gen`:
  - Parameterized by `DIV`.
  - Ports: clk, rst, tick.
  - Contains the prescaler and the registered pulse.
- The FSM, edge detect and count register stay in the top module.

## Test plan
Bench settings: `CLK_FREQ=100`, `TICK_HZ=10`, so DIV = 10.
- Reset then idle 50 cycles:
  - `tick_100ms` pulses at cycles 10, 20, 30, 40, 50.
  - `count_data` stays 0 and `running` stays 0.
- run_stop pulse, `sw_mode=0`, 35 cycles: `running`=1 and the count increments by 1 per tick.
  - A second run_stop pulse freezes the count.
  - Further ticks leave it unchanged.
- Down wrap, `sw_mode=1`, from count 0 in RUN:
  - Next tick → 9999.
  - With `UPDOWN_SATURATE_EN`: stays 0 and `running` drops to 0.
- Up wrap: force count to 9998 in RUN with `sw_mode=0`.
  - Two ticks → 9999, then 0.
  - Saturate build: 9999 holds and the FSM enters STOP.
- run_stop and clear rising in the same cycle while in RUN:
  - Count is 0 the next cycle.
  - State passes through CLEAR and lands in STOP.
  - `running`=0.
- `rst` asserted asynchronously mid-RUN at count 42:
  - Outputs go to reset values without a clk edge.
  - A button held across reset release produces no transition.
